// File: rtl/rts_cts_flow_ctrl.sv
// Purpose: per-channel RTS/CTS responder: synchronise + glitch-filter rts, wait a turnaround delay, drive registered cts.
// Latency: rts rise -> cts rise G_SYNC_STAGES+G_FILT_CNT+D cycles; rts fall -> cts fall G_SYNC_STAGES+G_FILT_CNT cycles.
// Backpressure: none; cts itself is the flow-control output. Macro RTS_TIMEOUT_EN adds a cts-high timeout, LOCKOUT state and o_timeout.
module rts_cts_flow_ctrl #(
  parameter int G_CHANNELS    = 4,
  parameter int G_SYNC_STAGES = 2,
  parameter int G_FILT_CNT    = 4,
`ifdef RTS_TIMEOUT_EN
  parameter int G_TIMEOUT     = 1000,
`endif
  parameter int G_DLY_W       = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_enable,
  input  logic [G_DLY_W-1:0]    i_cts_dly,
  input  logic [G_CHANNELS-1:0] i_rts,
  output logic [G_CHANNELS-1:0] o_cts,
  output logic [G_CHANNELS-1:0] o_rts_filt,
  output logic [G_CHANNELS-1:0] o_busy
`ifdef RTS_TIMEOUT_EN
  , output logic [G_CHANNELS-1:0] o_timeout
`endif
);

  // Filter counter only needs to reach G_FILT_CNT-1 before the output toggles.
  localparam int FCNT_W = (G_FILT_CNT > 1) ? $clog2(G_FILT_CNT) : 1;
  localparam logic [FCNT_W-1:0]  FCNT_LAST = FCNT_W'(G_FILT_CNT - 1);
  localparam logic [G_DLY_W-1:0] DCNT_ONE  = G_DLY_W'(1);
`ifdef RTS_TIMEOUT_EN
  localparam int TCNT_W = (G_TIMEOUT > 1) ? $clog2(G_TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(G_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2
`ifdef RTS_TIMEOUT_EN
    , ST_LOCKOUT = 2'd3
`endif
  } state_t;

  for (genvar ch = 0; ch < G_CHANNELS; ch++) begin : g_ch
    logic [G_SYNC_STAGES-1:0] sync_q;
    logic                     rts_sync;
    logic [FCNT_W-1:0]        fcnt_q, fcnt_d;
    logic                     filt_q, filt_d;
    state_t                   state_q, state_d;
    logic [G_DLY_W-1:0]       dcnt_q, dcnt_d;
    logic                     cts_q, cts_d;
    logic                     busy_q, busy_d;
    logic                     go;
`ifdef RTS_TIMEOUT_EN
    logic [TCNT_W-1:0]        tcnt_q, tcnt_d;
    logic                     tout_q, tout_d;
`endif

    assign rts_sync = sync_q[G_SYNC_STAGES-1];
    // A channel may only leave or stay out of IDLE while enabled and filtered rts is high.
    assign go       = i_enable & filt_q;

    // Plain flop chain: the first stage may go metastable, later stages let it resolve.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) sync_q <= '0;
      else         sync_q <= {sync_q[G_SYNC_STAGES-2:0], i_rts[ch]};
    end

    // Count consecutive mismatch cycles; toggle the filtered level once the run is long enough.
    always_comb begin
      fcnt_d = '0;
      filt_d = filt_q;
      if (rts_sync != filt_q) begin
        if (fcnt_q == FCNT_LAST) filt_d = ~filt_q;
        else                     fcnt_d = fcnt_q + 1'b1;
      end
    end

    // Filter state registers.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
        fcnt_q <= '0;
        filt_q <= 1'b0;
      end else begin
        fcnt_q <= fcnt_d;
        filt_q <= filt_d;
      end
    end

    // Next-state logic; losing enable or filtered rts always wins over counting.
    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
`ifdef RTS_TIMEOUT_EN
      tcnt_d  = tcnt_q;
      tout_d  = tout_q;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            if (i_cts_dly == '0) begin
              state_d = ST_ACTIVE;
`ifdef RTS_TIMEOUT_EN
              tcnt_d  = '0;
`endif
            end else begin
              // Delay is captured here, so later changes to i_cts_dly do not disturb the count.
              state_d = ST_DELAY;
              dcnt_d  = i_cts_dly;
            end
          end
        end
        ST_DELAY: begin
          if (!go) begin
            state_d = ST_IDLE;
            dcnt_d  = '0;
          end else if (dcnt_q == DCNT_ONE) begin
            state_d = ST_ACTIVE;
            dcnt_d  = '0;
`ifdef RTS_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end else begin
            dcnt_d  = dcnt_q - DCNT_ONE;
          end
        end
        ST_ACTIVE: begin
          if (!go) state_d = ST_IDLE;
`ifdef RTS_TIMEOUT_EN
          else if (tcnt_q == TCNT_LAST) begin
            state_d = ST_LOCKOUT;
            tout_d  = 1'b1;
          end else begin
            tcnt_d  = tcnt_q + 1'b1;
          end
`endif
        end
`ifdef RTS_TIMEOUT_EN
        ST_LOCKOUT: begin
          // Stay locked until the peer actually releases rts (or the block is disabled).
          if (!go) state_d = ST_IDLE;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
`ifdef RTS_TIMEOUT_EN
      if (!i_enable && !filt_q) tout_d = 1'b0;
`endif
      cts_d  = (state_d == ST_ACTIVE);
      busy_d = (state_d == ST_DELAY) || (state_d == ST_ACTIVE);
    end

    // FSM and output registers; outputs are decoded from next state so they line up with it.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
        state_q <= ST_IDLE;
        dcnt_q  <= '0;
        cts_q   <= 1'b0;
        busy_q  <= 1'b0;
`ifdef RTS_TIMEOUT_EN
        tcnt_q  <= '0;
        tout_q  <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        cts_q   <= cts_d;
        busy_q  <= busy_d;
`ifdef RTS_TIMEOUT_EN
        tcnt_q  <= tcnt_d;
        tout_q  <= tout_d;
`endif
      end
    end

    assign o_cts[ch]      = cts_q;
    assign o_rts_filt[ch] = filt_q;
    assign o_busy[ch]     = busy_q;
`ifdef RTS_TIMEOUT_EN
    assign o_timeout[ch]  = tout_q;
`endif
  end

endmodule

// File: tb/tb_rts_cts_flow_ctrl.sv
// Bench for rts_cts_flow_ctrl: table of pulses checked by an event scoreboard, plus hand sequences
// for enable drop in DELAY, asynchronous reset, and (with RTS_TIMEOUT_EN) timeout/lockout.
`timescale 1ns/1ps
module tb_rts_cts_flow_ctrl;
  localparam int CH = 4;
  localparam int S  = 2;
  localparam int F  = 4;
  localparam int DW = 8;
  localparam int L  = S + F;
  localparam int NV = 9;

  logic          i_Clock = 1'b0;
  logic          i_Reset;
  logic          i_enable;
  logic [DW-1:0] i_cts_dly;
  logic [CH-1:0] i_rts;
  logic [CH-1:0] o_cts, o_rts_filt, o_busy;
`ifdef RTS_TIMEOUT_EN
  logic [CH-1:0] o_timeout;
`endif

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  bit mon_en = 1'b0;

  rts_cts_flow_ctrl #(
    .G_CHANNELS    (CH),
    .G_SYNC_STAGES (S),
    .G_FILT_CNT    (F),
`ifdef RTS_TIMEOUT_EN
    .G_TIMEOUT     (16),
`endif
    .G_DLY_W       (DW)
  ) dut (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_enable   (i_enable),
    .i_cts_dly  (i_cts_dly),
    .i_rts      (i_rts),
    .o_cts      (o_cts),
    .o_rts_filt (o_rts_filt),
    .o_busy     (o_busy)
`ifdef RTS_TIMEOUT_EN
    , .o_timeout (o_timeout)
`endif
  );

  always #5 i_Clock = ~i_Clock;
  always @(posedge i_Clock) edge_n <= edge_n + 1;

  // Scoreboard of expected output transitions: kind 0=filt, 1=busy, 2=cts.
  typedef struct { int kind; int ch; int cyc; bit val; } ev_t;
  ev_t sb[$];

  typedef struct { int ch; int dly; int hi; bit exp_filt; bit exp_cts; } vec_t;
  vec_t vecs[NV];

  logic [CH-1:0] prev_v [3];

  function automatic string kname(input int k);
    case (k)
      0:       return "filt";
      1:       return "busy";
      default: return "cts";
    endcase
  endfunction

  function automatic logic [CH-1:0] kind_vec(input int k);
    case (k)
      0:       return o_rts_filt;
      1:       return o_busy;
      default: return o_cts;
    endcase
  endfunction

  task automatic push_ev(input int kind, input int ch, input int cyc, input bit val);
    ev_t e;
    e.kind = kind; e.ch = ch; e.cyc = cyc; e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_match(input int k, input int c, input logic v);
    int idx;
    idx = -1;
    for (int i = 0; i < sb.size(); i++)
      if (idx < 0 && sb[i].kind == k && sb[i].ch == c) idx = i;
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_%s[%0d]: went to %b at edge %0d, required no change", kname(k), c, v, edge_n);
    end else begin
      if (sb[idx].cyc != edge_n || sb[idx].val !== v) begin
        errors++;
        $display("FAIL %s[%0d]: got %b at edge %0d, required %b at edge %0d",
                 kname(k), c, v, edge_n, sb[idx].val, sb[idx].cyc);
      end
      sb.delete(idx);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_until(input int n);
    while (edge_n < n) @(negedge i_Clock);
  endtask

  // Watch every output bit for changes and reconcile them against the scoreboard.
  always @(negedge i_Clock) begin
    for (int k = 0; k < 3; k++) begin
      logic [CH-1:0] cur;
      cur = kind_vec(k);
      for (int c = 0; c < CH; c++)
        if (mon_en && cur[c] !== prev_v[k][c]) sb_match(k, c, cur[c]);
      prev_v[k] = cur;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal finish");
    $fatal(1);
  end

  initial begin
    int t0, e, r;
    bit ok;
    i_Reset = 1'b0; i_enable = 1'b0; i_cts_dly = '0; i_rts = '0;

    //          ch dly  hi  filt cts
    vecs[0] = '{0,  3,  20, 1'b1, 1'b1};  // basic rise 2+4+3
    vecs[1] = '{1,  0,  12, 1'b1, 1'b1};  // zero delay, fall after 6
    vecs[2] = '{2,  2,   3, 1'b0, 1'b0};  // 3-cycle glitch filtered out
    vecs[3] = '{2,  5,   4, 1'b1, 1'b0};  // 4-cycle pulse passes filter, too short for delay
    vecs[4] = '{3,  1,   4, 1'b1, 1'b1};  // minimal nonzero delay
    vecs[5] = '{0,  1,   2, 1'b0, 1'b0};  // short glitch
    vecs[6] = '{3, 255, 300, 1'b1, 1'b1}; // maximum delay must not wrap
    vecs[7] = '{1,  7,   7, 1'b1, 1'b0};  // rts drops on the edge delay would expire
    vecs[8] = '{2,  6,   7, 1'b1, 1'b1};  // single-cycle cts pulse

    #1 i_Reset = 1'b1;
    #2;
    chk("reset_cts",  o_cts,      '0);
    chk("reset_filt", o_rts_filt, '0);
    chk("reset_busy", o_busy,     '0);
    repeat (3) @(negedge i_Clock);
    i_Reset = 1'b0; i_enable = 1'b1;
    repeat (2) @(negedge i_Clock);
    mon_en = 1'b1;

    for (int i = 0; i < NV; i++) begin
      i_cts_dly = DW'(vecs[i].dly);
      i_rts[vecs[i].ch] = 1'b1;
      t0 = edge_n + 1;
      if (vecs[i].exp_filt) begin
        push_ev(0, vecs[i].ch, t0 + L - 1,            1'b1);
        push_ev(0, vecs[i].ch, t0 + vecs[i].hi + L - 1, 1'b0);
        push_ev(1, vecs[i].ch, t0 + L,                1'b1);
        push_ev(1, vecs[i].ch, t0 + vecs[i].hi + L,   1'b0);
      end
      if (vecs[i].exp_cts) begin
        push_ev(2, vecs[i].ch, t0 + L + vecs[i].dly,  1'b1);
        push_ev(2, vecs[i].ch, t0 + vecs[i].hi + L,   1'b0);
      end
      repeat (vecs[i].hi) @(negedge i_Clock);
      i_rts[vecs[i].ch] = 1'b0;
      repeat (L + 8) @(negedge i_Clock);
      chk($sformatf("drain_v%0d", i), sb.size(), 0);
    end

    // Enable dropped on the third DELAY cycle, then restored.
    mon_en = 1'b0;
    i_cts_dly = DW'(10);
    i_rts[0] = 1'b1;
    t0 = edge_n + 1;
    wait_until(t0 + L + 2);
    chk("dly_busy_before_dis", o_busy[0], 1);
    chk("dly_cts_before_dis",  o_cts[0],  0);
    i_enable = 1'b0;
    @(negedge i_Clock);
    chk("dis_busy_idle", o_busy[0], 0);
    ok = 1'b1;
    repeat (12) begin
      @(negedge i_Clock);
      if (o_cts[0] !== 1'b0 || o_busy[0] !== 1'b0) ok = 1'b0;
    end
    chk("dis_held_idle", ok, 1);
    i_enable = 1'b1;
    e = edge_n + 1;
    wait_until(e + 9);
    chk("reen_cts_not_early", o_cts[0], 0);
    @(negedge i_Clock);
    chk("reen_cts_full_delay", o_cts[0], 1);
    i_rts[0] = 1'b0;
    repeat (L + 4) @(negedge i_Clock);
    chk("reen_cts_release", o_cts[0], 0);

    // Asynchronous reset pulse between clock edges with every channel granted.
    i_cts_dly = '0;
    i_rts = '1;
    t0 = edge_n + 1;
    wait_until(t0 + L);
    chk("all_cts_up", o_cts, 4'hF);
    @(posedge i_Clock);
    #2 i_Reset = 1'b1;
    #1;
    chk("arst_cts",  o_cts,      '0);
    chk("arst_busy", o_busy,     '0);
    chk("arst_filt", o_rts_filt, '0);
    #1 i_Reset = 1'b0;
    r = edge_n + 1;
    wait_until(r + L - 1);
    chk("post_rst_cts_not_early", o_cts, '0);
    @(negedge i_Clock);
    chk("post_rst_cts_up", o_cts, 4'hF);
    i_rts = '0;
    repeat (L + 4) @(negedge i_Clock);
    chk("post_rst_release", o_cts, '0);

`ifdef RTS_TIMEOUT_EN
    // cts held too long: lockout, blocked re-assertion, flag cleared by disable.
    i_rts[0] = 1'b1;
    t0 = edge_n + 1;
    wait_until(t0 + L);
    chk("to_cts_up", o_cts[0], 1);
    wait_until(t0 + L + 15);
    chk("to_cts_last", o_cts[0], 1);
    chk("to_flag_early", o_timeout[0], 0);
    @(negedge i_Clock);
    chk("to_cts_drop", o_cts[0], 0);
    chk("to_flag_set", o_timeout[0], 1);
    ok = 1'b1;
    repeat (10) begin
      @(negedge i_Clock);
      if (o_cts[0] !== 1'b0) ok = 1'b0;
    end
    i_rts[0] = 1'b0;
    repeat (3) @(negedge i_Clock);
    i_rts[0] = 1'b1;
    repeat (15) begin
      @(negedge i_Clock);
      if (o_cts[0] !== 1'b0 || o_busy[0] !== 1'b0) ok = 1'b0;
    end
    chk("to_lockout_held", ok, 1);
    i_rts[0] = 1'b0;
    repeat (L + 2) @(negedge i_Clock);
    i_rts[0] = 1'b1;
    t0 = edge_n + 1;
    wait_until(t0 + L);
    chk("to_regrant", o_cts[0], 1);
    chk("to_flag_sticky", o_timeout[0], 1);
    i_rts[0] = 1'b0;
    repeat (L + 4) @(negedge i_Clock);
    i_enable = 1'b0;
    repeat (2) @(negedge i_Clock);
    chk("to_flag_clear", o_timeout[0], 0);
    i_enable = 1'b1;
`endif

    repeat (4) @(negedge i_Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
